// File: rtl/conv2_window_buffer_if.sv
// Pixel-stream and window-output bundle of the second-layer window buffer.
// The master drives pixel beats; the slave returns three 3x3 windows plus frame strobes.
interface conv2_window_buffer_if #(
  parameter int CONV_BIT = 12
);
  logic                  valid_in;
  logic [CONV_BIT-1:0]   data_in_1;
  logic [CONV_BIT-1:0]   data_in_2;
  logic [CONV_BIT-1:0]   data_in_3;
  logic [9*CONV_BIT-1:0] window_1;
  logic [9*CONV_BIT-1:0] window_2;
  logic [9*CONV_BIT-1:0] window_3;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output valid_in, data_in_1, data_in_2, data_in_3,
    input  window_1, window_2, window_3, valid_out, frame_done
  );

  modport slave (
    input  valid_in, data_in_1, data_in_2, data_in_3,
    output window_1, window_2, window_3, valid_out, frame_done
  );
endinterface

// File: rtl/conv2_window_buffer.sv
// Sliding 3x3 window generator for three channels of the pooled feature map.
// Two line buffers per channel feed a shifting window; complete windows are registered out.
module conv2_window_buffer #(
  parameter int CONV_BIT       = 12,
  parameter int HALF_WIDTH     = 12,
  parameter int HALF_HEIGHT    = 12,
  parameter int HALF_WIDTH_BIT = 4
) (
  input logic clk,
  input logic rst_n,
  conv2_window_buffer_if.slave bus
);

  localparam logic [HALF_WIDTH_BIT-1:0] LAST_COL = HALF_WIDTH_BIT'(HALF_WIDTH - 1);
  localparam logic [HALF_WIDTH_BIT-1:0] LAST_ROW = HALF_WIDTH_BIT'(HALF_HEIGHT - 1);
  localparam logic [HALF_WIDTH_BIT-1:0] TWO      = HALF_WIDTH_BIT'(2);

  logic [HALF_WIDTH_BIT-1:0] col_q, col_d;
  logic [HALF_WIDTH_BIT-1:0] row_q, row_d;
  logic                      valid_q, frameDone_q;
  logic                      complete, frameEnd;

  logic [CONV_BIT-1:0]   dataIn    [3];
  logic [CONV_BIT-1:0]   lbA_q     [3][HALF_WIDTH];
  logic [CONV_BIT-1:0]   lbB_q     [3][HALF_WIDTH];
  logic [CONV_BIT-1:0]   win_q     [3][9];
  logic [CONV_BIT-1:0]   win_d     [3][9];
  logic [9*CONV_BIT-1:0] winPacked_d [3];
  logic [9*CONV_BIT-1:0] winOut_q    [3];

  assign dataIn[0] = bus.data_in_1;
  assign dataIn[1] = bus.data_in_2;
  assign dataIn[2] = bus.data_in_3;

  assign complete = bus.valid_in && (row_q >= TWO) && (col_q >= TWO);
  assign frameEnd = complete && (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.valid_in) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Right column is read from the line buffers before this beat's write lands.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      winPacked_d[ch] = '0;
      for (int r = 0; r < 3; r++) begin
        win_d[ch][3*r]     = win_q[ch][3*r+1];
        win_d[ch][3*r + 1] = win_q[ch][3*r+2];
      end
      win_d[ch][2] = lbB_q[ch][col_q];
      win_d[ch][5] = lbA_q[ch][col_q];
      win_d[ch][8] = dataIn[ch];
      for (int e = 0; e < 9; e++) begin
        winPacked_d[ch][e*CONV_BIT +: CONV_BIT] = win_d[ch][e];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.valid_in) begin
      for (int ch = 0; ch < 3; ch++) begin
        lbB_q[ch][col_q] <= lbA_q[ch][col_q];
        lbA_q[ch][col_q] <= dataIn[ch];
        for (int e = 0; e < 9; e++) begin
          win_q[ch][e] <= win_d[ch][e];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      valid_q     <= 1'b0;
      frameDone_q <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        winOut_q[ch] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      valid_q     <= complete;
      frameDone_q <= frameEnd;
      if (complete) begin
        for (int ch = 0; ch < 3; ch++) begin
          winOut_q[ch] <= winPacked_d[ch];
        end
      end
    end
  end

  assign bus.window_1   = winOut_q[0];
  assign bus.window_2   = winOut_q[1];
  assign bus.window_3   = winOut_q[2];
  assign bus.valid_out  = valid_q;
  assign bus.frame_done = frameDone_q;

endmodule
